// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction controller: state encoding,
// default geometry and the SPI mode this block implements.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam int   SPI_MODE = 0;
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles o_sclk every CLK_DIV enabled cycles and flags the
// edge that the current cycle's terminal count will produce.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int                CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  DIV_TC = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tc;

    assign w_tc = i_en && (r_cnt == DIV_TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_sclk <= SPI_CPOL;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_sclk <= SPI_CPOL;
        end else if (i_en) begin
            if (w_tc) begin
                r_cnt  <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Strobes lead the register by one edge so the FSM acts on the same edge SCLK moves.
    assign o_rise = w_tc && !r_sclk;
    assign o_fall = w_tc && r_sclk;
    assign o_sclk = r_sclk;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Mode-0 single-word SPI master: sequences CS, MOSI shifting and MISO
// sampling around the divided SCLK, one DATA_WIDTH-bit word per start.
//
// state    | meaning
// ST_IDLE  | CS high, waiting for i_start
// ST_SETUP | CS low, MSB on MOSI, CLK_DIV cycles before first SCLK edge
// ST_XFER  | SCLK running, DATA_WIDTH rising edges
// ST_HOLD  | CS low, SCLK low, CLK_DIV cycles before release
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sclk,
    output logic                  o_mosi,
    input  logic                  i_miso,
    output logic                  o_cs_n
);

    localparam int                WAIT_W   = $clog2(CLK_DIV);
    localparam int                BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [WAIT_W-1:0] WAIT_TC  = WAIT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH);

    generate
        if (CLK_DIV < 2 || DATA_WIDTH < 2) begin : g_bad_param
            $error("spi_xfer_ctrl: CLK_DIV and DATA_WIDTH must both be >= 2");
        end
    endgenerate

    spi_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_tx_sr;
    logic [DATA_WIDTH-1:0] r_rx_sr;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [WAIT_W-1:0]     r_wait;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_busy;
    logic                  r_cs_n;
    logic                  r_done;
    logic                  w_xfer;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_sclk;

    assign w_xfer = (r_state == ST_XFER);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_xfer),
        .i_clr   (!w_xfer),
        .o_sclk  (w_sclk),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_wait    <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_tx_sr   <= i_tx_data;
                        r_rx_sr   <= '0;
                        r_bit_cnt <= '0;
                        r_wait    <= WAIT_TC;
                        r_busy    <= 1'b1;
                        r_cs_n    <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_wait == '0) begin
                        r_state <= ST_XFER;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_rise) begin
                        r_rx_sr   <= {r_rx_sr[DATA_WIDTH-2:0], i_miso};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    // Last falling edge leaves MOSI on the final bit through HOLD.
                    if (w_fall) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_wait  <= WAIT_TC;
                            r_state <= ST_HOLD;
                        end else begin
                            r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_wait == '0) begin
                        r_rx_data <= r_rx_sr;
                        r_busy    <= 1'b0;
                        r_cs_n    <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rx_data = r_rx_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_sclk    = w_sclk;
    assign o_mosi    = r_tx_sr[DATA_WIDTH-1];
    assign o_cs_n    = r_cs_n;

endmodule
